conv_acc_ctrl: RTL and testbench
================================

Name: conv_acc_ctrl

Overview:
Sequencer for the 2D convolution datapath. It walks a valid-mode KxK window over an IMG_W x IMG_H image held in a synchronous-read pixel memory, with weights in a synchronous-read weight memory. It issues pixel and weight addresses, drives the accumulator's en/load_new_value controls, and presents each finished output pixel through a valid/ready handshake. It sits between the top-level start/done control, the two memories and the accumulator.

Parameters:
IMG_W, 8, image width in pixels (>= K)
IMG_H, 8, image height in pixels (>= K)
K, 3, kernel side length (>= 1)
PIX_AW, 6, pixel address width (holds IMG_W*IMG_H-1)
WGT_AW, 4, weight address width (holds K*K-1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle request to begin a full image pass
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last output pixel is accepted
rd_en  out  1  read strobe to both memories
pix_addr  out  PIX_AW  pixel memory address
wgt_addr  out  WGT_AW  weight memory address
acc_en  out  1  to accumulator en
acc_load  out  1  to accumulator load_new_value
out_valid  out  1  accumulator output holds a complete window sum
out_ready  in  1  downstream accepts the current output pixel
out_row  out  clog2(IMG_H-K+1) max 1  output row index of the current result
out_col  out  clog2(IMG_W-K+1) max 1  output column index of the current result

Behaviour:
- Reset (rst==0 at posedge): state IDLE. All outputs and all counters are 0. Reset mid-pass aborts the pass immediately; no done pulse.
- Derived values: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1. Output pixels are produced in raster order, row-major.
- States: IDLE, RUN, DRAIN, OUT, FIN.
- IDLE: start=1 -> RUN with r=c=0 and taps i=j=0. busy goes high the next cycle. start is ignored in every other state.
- RUN: rd_en=1 every cycle.
  - pix_addr = (r+i)*IMG_W + (c+j).
  - wgt_addr = i*K + j.
  - j increments; on wrap j=K-1 -> 0, i increments.
  - After the issue cycle with i=j=K-1, go to DRAIN.
  - RUN lasts exactly K*K cycles.
- Memory read latency is 1. acc_en is rd_en delayed one cycle through a register. acc_load is the delayed "tap==0" flag, so it is high only with the first tap of each window. acc_en is therefore high for K*K consecutive cycles, starting the cycle after RUN is entered.
- DRAIN: one cycle, carrying the final acc_en. rd_en=0. Next state is OUT.
- OUT: out_valid=1; out_row=r, out_col=c are stable. acc_en=0, so the accumulator holds its value.
  - out_ready=0: stay in OUT with all outputs held.
  - out_ready=1 and (r,c) is not the last pixel: advance c, wrapping to the next row at OUT_W-1. Go to RUN with i=j=0.
  - out_ready=1 and r=OUT_H-1, c=OUT_W-1: go to FIN.
- FIN: done=1 for one cycle, busy=0. Next state is IDLE.
- Timing: with out_ready tied high, each output pixel takes K*K+2 cycles. A full pass takes OUT_W*OUT_H*(K*K+2)+1 cycles from the first RUN cycle to the done pulse.
- out_valid is asserted only in OUT. acc_en and out_valid are never high in the same cycle.
- K=1: RUN lasts 1 cycle and acc_load=1 with every acc_en.
- All outputs are registered, except rd_en, pix_addr and wgt_addr, which are decoded from registered state and counters.

Decomposition:
- Package conv_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, OUT, FIN);
  - default IMG_W, IMG_H, K;
  - functions for OUT_W/OUT_H and the counter widths.
- Sub-module conv_win_addr_gen contains the r/c/i/j counters and the address arithmetic.
  - Inputs: step_tap, step_pix, clear.
  - Outputs: pix_addr, wgt_addr, last_tap, last_pix, r, c.
- conv_acc_ctrl contains the FSM, the one-cycle acc_en/acc_load delay, and the handshake.

Test Plan:
- IMG_W=IMG_H=4, K=3, out_ready=1, start pulse -> pix_addr for (0,0) is 0,1,2,4,5,6,8,9,10 and wgt_addr is 0..8. acc_load is high only on the first acc_en, one cycle after pix_addr=0.
- Same config, full pass -> out_valid pulses 4 times with (row,col) = (0,0),(0,1),(1,0),(1,1). Window (1,1) addresses are 5,6,7,9,10,11,13,14,15. done pulses 45 cycles after the first RUN cycle; busy then drops.
- Hold out_ready=0 for 5 cycles at pixel (0,1) -> out_valid, out_row=0, out_col=1 stay stable and rd_en/acc_en stay 0. Raising out_ready restarts RUN with pix_addr=4 on the next cycle.
- start re-pulsed while busy -> ignored; the address sequence is unchanged and only one done pulse occurs.
- rst=0 during RUN of pixel (1,0) -> next cycle all outputs are 0 and the state is IDLE. A new start replays from pix_addr=0.
- K=1, IMG_W=IMG_H=2 -> 4 pixels, 3 cycles each, acc_load=1 with every acc_en, pix_addr=0,1,2,3.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 2D convolution sequencer:
//   - state_t      : sequencer states (IDLE, RUN, DRAIN, OUT, FIN)
//   - DEF_*        : default image / kernel geometry and address widths
//   - out_dim()    : output dimension of a valid-mode window walk
//   - cnt_w()      : counter width able to hold 0..n-1 (never below 1 bit)
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DEF_IMG_W  = 8;
    localparam int DEF_IMG_H  = 8;
    localparam int DEF_K      = 3;
    localparam int DEF_PIX_AW = 6;
    localparam int DEF_WGT_AW = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT,
        FIN
    } state_t;

    // Number of window positions along one axis (valid mode, stride 1).
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // Width of a counter running 0..n-1; a single position still needs 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_win_addr_gen
// Window / tap counters and address arithmetic for the convolution walk.
//   clk, rst   : clock, synchronous active-low reset
//   step_tap   : advance tap (j fastest, then i), wrapping to 0 after K*K taps
//   step_pix   : advance output pixel (c fastest, then r), raster order
//   clear      : return all counters to 0 (start of a pass)
//   pix_addr   : (r+i)*IMG_W + (c+j)
//   wgt_addr   : i*K + j
//   last_tap   : current tap is i=j=K-1
//   last_pix   : current output pixel is the bottom-right one
//   r, c       : current output row / column
// ---------------------------------------------------------------------------
module conv_win_addr_gen import conv_pkg::*; #(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int PIX_AW = DEF_PIX_AW,
    parameter int WGT_AW = DEF_WGT_AW
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  step_tap,
    input  logic                                  step_pix,
    input  logic                                  clear,
    output logic [PIX_AW-1:0]                     pix_addr,
    output logic [WGT_AW-1:0]                     wgt_addr,
    output logic                                  last_tap,
    output logic                                  last_pix,
    output logic [cnt_w(out_dim(IMG_H, K))-1:0]   r,
    output logic [cnt_w(out_dim(IMG_W, K))-1:0]   c
);

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int ROW_W = cnt_w(OUT_H);
    localparam int COL_W = cnt_w(OUT_W);
    localparam int TAP_W = cnt_w(K);

    logic [TAP_W-1:0]  i;
    logic [TAP_W-1:0]  j;
    logic              last_i;
    logic              last_j;
    logic              last_r;
    logic              last_c;
    logic [PIX_AW-1:0] win_row;
    logic [PIX_AW-1:0] win_col;

    assign last_j   = (j == TAP_W'(K - 1));
    assign last_i   = (i == TAP_W'(K - 1));
    assign last_c   = (c == COL_W'(OUT_W - 1));
    assign last_r   = (r == ROW_W'(OUT_H - 1));
    assign last_tap = last_i && last_j;
    assign last_pix = last_r && last_c;

    // Taps wrap back to 0 after the last one, so the next window starts
    // at i=j=0 without needing an explicit clear between pixels.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // counter updates from the same pre-edge values.
        if (!rst) begin
            i <= '0;
            j <= '0;
            r <= '0;
            c <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
            r <= '0;
            c <= '0;
        end else begin
            if (step_tap) begin
                j <= last_j ? '0 : j + TAP_W'(1);
                if (last_j) begin
                    i <= last_i ? '0 : i + TAP_W'(1);
                end
            end
            if (step_pix) begin
                c <= last_c ? '0 : c + COL_W'(1);
                if (last_c) begin
                    r <= last_r ? '0 : r + ROW_W'(1);
                end
            end
        end
    end

    // Every intermediate stays below IMG_W*IMG_H, so PIX_AW bits suffice.
    assign win_row  = PIX_AW'(r) + PIX_AW'(i);
    assign win_col  = PIX_AW'(c) + PIX_AW'(j);
    assign pix_addr = win_row * PIX_AW'(IMG_W) + win_col;
    assign wgt_addr = WGT_AW'(i) * WGT_AW'(K) + WGT_AW'(j);

endmodule

// File: rtl/conv_acc_ctrl.sv
// ---------------------------------------------------------------------------
// conv_acc_ctrl
// Sequencer for the 2D convolution datapath: walks a KxK valid-mode window
// over an IMG_W x IMG_H image, issues memory addresses, steers the
// accumulator and hands each finished window sum downstream.
//   clk, rst   : clock, synchronous active-low reset
//   start      : one-cycle pass request (honoured only in IDLE)
//   busy       : pass in progress (RUN/DRAIN/OUT)
//   done       : one-cycle pulse after the last output is accepted
//   rd_en      : read strobe to pixel and weight memories
//   pix_addr   : pixel memory address
//   wgt_addr   : weight memory address
//   acc_en     : accumulator enable (rd_en delayed by the read latency)
//   acc_load   : accumulator load_new_value (first tap of each window)
//   out_valid  : accumulator holds a complete window sum
//   out_ready  : downstream accepts the current output
//   out_row    : output row index of the current result
//   out_col    : output column index of the current result
// ---------------------------------------------------------------------------
module conv_acc_ctrl import conv_pkg::*; #(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int PIX_AW = DEF_PIX_AW,
    parameter int WGT_AW = DEF_WGT_AW
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  rd_en,
    output logic [PIX_AW-1:0]                     pix_addr,
    output logic [WGT_AW-1:0]                     wgt_addr,
    output logic                                  acc_en,
    output logic                                  acc_load,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [cnt_w(out_dim(IMG_H, K))-1:0]   out_row,
    output logic [cnt_w(out_dim(IMG_W, K))-1:0]   out_col
);

    localparam int ROW_W = cnt_w(out_dim(IMG_H, K));
    localparam int COL_W = cnt_w(out_dim(IMG_W, K));

    state_t           state;
    state_t           state_next;
    logic             step_tap;
    logic             step_pix;
    logic             clear;
    logic             last_tap;
    logic             last_pix;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;

    conv_win_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .PIX_AW (PIX_AW),
        .WGT_AW (WGT_AW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .step_tap (step_tap),
        .step_pix (step_pix),
        .clear    (clear),
        .pix_addr (pix_addr),
        .wgt_addr (wgt_addr),
        .last_tap (last_tap),
        .last_pix (last_pix),
        .r        (r),
        .c        (c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        step_tap   = 1'b0;
        step_pix   = 1'b0;
        clear      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                step_tap = 1'b1;
                if (last_tap) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (last_pix) begin
                        state_next = FIN;
                        clear      = 1'b1;
                    end else begin
                        state_next = RUN;
                        step_pix   = 1'b1;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rd_en = (state == RUN);

    // Registered outputs are loaded from the next state so they line up
    // with the state they describe. acc_en/acc_load follow the issue cycle
    // by one clock to match the synchronous memory read latency; a zero
    // weight address marks the first tap of a window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_en    <= 1'b0;
            acc_load  <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            busy      <= (state_next inside {RUN, DRAIN, OUT});
            done      <= (state_next == FIN);
            acc_en    <= rd_en;
            acc_load  <= rd_en && (wgt_addr == '0);
            out_valid <= (state_next == OUT);
            out_row   <= (state_next == OUT) ? r : '0;
            out_col   <= (state_next == OUT) ? c : '0;
        end
    end

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_acc_ctrl
// Main instance: 4x4 image, K=3 (2x2 outputs). Second instance: 2x2, K=1.
// Issued addresses are scored against a queue filled when a pass starts;
// per-pixel row/col and stall behaviour come from a vector table.
// ---------------------------------------------------------------------------
module tb_conv_acc_ctrl;

    typedef struct {
        int stall;
        int exp_row;
        int exp_col;
    } pix_vec_t;

    typedef struct {
        int pix;
        int wgt;
    } addr_rec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [3:0] pix_addr;
    logic [3:0] wgt_addr;
    logic       acc_en;
    logic       acc_load;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_row;
    logic [0:0] out_col;

    logic       k1_start;
    logic       k1_busy;
    logic       k1_done;
    logic       k1_rd_en;
    logic [1:0] k1_pix_addr;
    logic [0:0] k1_wgt_addr;
    logic       k1_acc_en;
    logic       k1_acc_load;
    logic       k1_out_valid;
    logic       k1_out_ready;
    logic [0:0] k1_out_row;
    logic [0:0] k1_out_col;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_run;
    int done_at;
    int done_cnt;

    pix_vec_t  vecs [4];
    addr_rec_t addr_q [$];
    logic      pend_en   = 1'b0;
    logic      pend_load = 1'b0;

    conv_acc_ctrl #(
        .IMG_W (4), .IMG_H (4), .K (3), .PIX_AW (4), .WGT_AW (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .pix_addr  (pix_addr),
        .wgt_addr  (wgt_addr),
        .acc_en    (acc_en),
        .acc_load  (acc_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    conv_acc_ctrl #(
        .IMG_W (2), .IMG_H (2), .K (1), .PIX_AW (2), .WGT_AW (1)
    ) dut_k1 (
        .clk       (clk),
        .rst       (rst),
        .start     (k1_start),
        .busy      (k1_busy),
        .done      (k1_done),
        .rd_en     (k1_rd_en),
        .pix_addr  (k1_pix_addr),
        .wgt_addr  (k1_wgt_addr),
        .acc_en    (k1_acc_en),
        .acc_load  (k1_acc_load),
        .out_valid (k1_out_valid),
        .out_ready (k1_out_ready),
        .out_row   (k1_out_row),
        .out_col   (k1_out_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_en && first_run < 0) first_run = cyc;
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_rd_en"},     rd_en,     0);
        check({tag, "_pix_addr"},  pix_addr,  0);
        check({tag, "_wgt_addr"},  wgt_addr,  0);
        check({tag, "_acc_en"},    acc_en,    0);
        check({tag, "_acc_load"},  acc_load,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_row"},   out_row,   0);
        check({tag, "_out_col"},   out_col,   0);
    endtask

    // Expected address stream of one full pass, raster windows, taps j-fastest.
    task automatic push_pass();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        addr_q.push_back('{pix: (r + i) * 4 + c + j, wgt: i * 3 + j});
    endtask

    // Scoreboard monitor: addresses on every issue, accumulator controls
    // one cycle later, and exclusivity of acc_en and out_valid.
    always @(negedge clk) begin
        if (!rst) begin
            addr_q.delete();
            pend_en   <= 1'b0;
            pend_load <= 1'b0;
        end else begin
            check("acc_en_delay",   acc_en,   pend_en);
            check("acc_load_delay", acc_load, pend_load);
            check("acc_en_vs_out_valid", acc_en & out_valid, 0);
            pend_en   <= rd_en;
            pend_load <= 1'b0;
            if (rd_en) begin
                check("scb_issue_expected", (addr_q.size() != 0) ? 32'd1 : 32'd0, 1);
                if (addr_q.size() != 0) begin
                    check("scb_pix_addr", pix_addr, addr_q[0].pix);
                    check("scb_wgt_addr", wgt_addr, addr_q[0].wgt);
                    pend_load <= (addr_q[0].wgt == 0);
                    addr_q.delete(0);
                end
            end
        end
    end

    task automatic run_pass(input bit use_stall, input bit repulse);
        int n;
        push_pass();
        done_cnt  = 0;
        first_run = -1;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        check("busy_after_start", busy, 1);
        check("first_pix_addr", pix_addr, 0);
        if (repulse) begin
            step();
            step();
        end
        start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            out_ready = !(use_stall && vecs[p].stall > 0);
            n = 0;
            while (!out_valid && n < 40) begin
                step();
                n++;
            end
            check("out_valid_seen", out_valid, 1);
            check("out_row", out_row, vecs[p].exp_row);
            check("out_col", out_col, vecs[p].exp_col);
            check("busy_in_out", busy, 1);
            if (use_stall && vecs[p].stall > 0) begin
                for (int s = 1; s < vecs[p].stall; s++) begin
                    step();
                    check("stall_out_valid", out_valid, 1);
                    check("stall_out_row", out_row, vecs[p].exp_row);
                    check("stall_out_col", out_col, vecs[p].exp_col);
                    check("stall_rd_en", rd_en, 0);
                    check("stall_acc_en", acc_en, 0);
                end
                out_ready = 1'b1;
                step();
                if (p < 3) begin
                    check("restart_rd_en", rd_en, 1);
                    check("restart_pix_addr", pix_addr,
                          vecs[p + 1].exp_row * 4 + vecs[p + 1].exp_col);
                end
            end else begin
                step();
            end
        end
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        if (!use_stall && !repulse) check("pass_latency", done_at - first_run, 44);
        step();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        step();
        step();
        check("done_count", done_cnt, 1);
        check("scb_queue_drained", addr_q.size(), 0);
    endtask

    task automatic run_abort();
        int n;
        push_pass();
        done_cnt  = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_col == 1'b1) && n < 60) begin
            step();
            n++;
        end
        check("abort_reach_pix01", out_valid, 1);
        step();
        step();
        step();
        check("abort_in_run", rd_en, 1);
        check("abort_pix_addr", pix_addr, 6);
        rst = 1'b0;
        step();
        check_reset_outputs("midpass_rst");
        rst = 1'b1;
        step();
        step();
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_rd_en", rd_en, 0);
    endtask

    task automatic run_k1();
        int issue;
        int pix;
        int acc_cnt;
        int run0;
        int d_at;
        issue        = 0;
        pix          = 0;
        acc_cnt      = 0;
        run0         = -1;
        d_at         = -1;
        k1_out_ready = 1'b1;
        k1_start     = 1'b1;
        for (int t = 0; t < 30; t++) begin
            step();
            k1_start = 1'b0;
            if (k1_rd_en) begin
                check("k1_pix_addr", k1_pix_addr, issue);
                check("k1_wgt_addr", k1_wgt_addr, 0);
                if (run0 < 0) run0 = t;
                issue++;
            end
            if (k1_acc_en) begin
                check("k1_acc_load", k1_acc_load, 1);
                acc_cnt++;
            end
            if (k1_out_valid) begin
                check("k1_out_row", k1_out_row, pix / 2);
                check("k1_out_col", k1_out_col, pix % 2);
                pix++;
            end
            if (k1_done) d_at = t;
        end
        check("k1_issue_count", issue, 4);
        check("k1_acc_count", acc_cnt, 4);
        check("k1_pixel_count", pix, 4);
        check("k1_pass_latency", d_at - run0, 12);
    endtask

    initial begin
        vecs[0] = '{stall: 0, exp_row: 0, exp_col: 0};
        vecs[1] = '{stall: 5, exp_row: 0, exp_col: 1};
        vecs[2] = '{stall: 0, exp_row: 1, exp_col: 0};
        vecs[3] = '{stall: 0, exp_row: 1, exp_col: 1};

        rst          = 1'b0;
        start        = 1'b0;
        out_ready    = 1'b1;
        k1_start     = 1'b0;
        k1_out_ready = 1'b1;
        first_run    = -1;
        done_at      = -1;
        done_cnt     = 0;

        step();
        step();
        step();
        check_reset_outputs("reset");
        check("reset_k1_busy", k1_busy, 0);
        rst = 1'b1;
        step();

        run_pass(1'b0, 1'b0);   // free-running pass, timing checked
        run_pass(1'b1, 1'b1);   // stall at (0,1), start re-pulsed while busy
        run_abort();            // reset during RUN of (1,0)
        run_pass(1'b0, 1'b0);   // replay after abort
        run_k1();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
